// File: rtl/axis_flit_deserializer.sv
// axis_flit_deserializer
//
// Receive endpoint for the ring's credit-based flit interface. Incoming flits
// go into a small FIFO. Each popped flit returns one credit. Each group of
// SERIALIZATION_FACTOR flits is reassembled into one AXI-Stream beat.
//
// Ports
//   clk, rst_n     NoC clock; synchronous active-low reset
//   data_in        flit payload (FLIT_WIDTH bits)
//   dest_in        flit destination (TID and TDEST concatenated)
//   is_tail_in     flit is the last flit of its packet
//   send_in        flit valid; there is no backpressure on this side
//   credit_out     one-cycle pulse per consumed flit (registered)
//   axis_*         AXI-Stream master: tvalid/tready/tdata/tlast/tdest
//   overflow_err   sticky: a flit arrived while the FIFO was full
//   tail_err       sticky: a tail flit arrived before the final slice
module axis_flit_deserializer #(
  parameter int unsigned TDEST_WIDTH          = 6,
  parameter int unsigned TDATA_WIDTH          = 512,
  parameter int unsigned SERIALIZATION_FACTOR = 4,
  parameter int unsigned FLIT_BUFFER_DEPTH    = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [TDATA_WIDTH/SERIALIZATION_FACTOR-1:0] data_in,
  input  logic [TDEST_WIDTH-1:0]                    dest_in,
  input  logic                                      is_tail_in,
  input  logic                                      send_in,
  output logic                                      credit_out,
  output logic                                      axis_tvalid,
  input  logic                                      axis_tready,
  output logic [TDATA_WIDTH-1:0]                    axis_tdata,
  output logic                                      axis_tlast,
  output logic [TDEST_WIDTH-1:0]                    axis_tdest,
  output logic                                      overflow_err,
  output logic                                      tail_err
);

  localparam int unsigned FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
  localparam int unsigned AsmWidth   = TDATA_WIDTH - FLIT_WIDTH;
  localparam int unsigned SliceW     = $clog2(SERIALIZATION_FACTOR);
  localparam int unsigned PtrW       = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
  localparam int unsigned CntW       = $clog2(FLIT_BUFFER_DEPTH + 1);

  localparam logic [SliceW-1:0] LastSlice = SliceW'(SERIALIZATION_FACTOR - 1);
  localparam logic [PtrW-1:0]   LastPtr   = PtrW'(FLIT_BUFFER_DEPTH - 1);
  localparam logic [CntW-1:0]   FullCnt   = CntW'(FLIT_BUFFER_DEPTH);

  // Flit FIFO storage; contents need no reset, occupancy is tracked by count_q.
  logic [FLIT_WIDTH-1:0]  data_mem [FLIT_BUFFER_DEPTH];
  logic [TDEST_WIDTH-1:0] dest_mem [FLIT_BUFFER_DEPTH];
  logic                   tail_mem [FLIT_BUFFER_DEPTH];

  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;

  logic [SliceW-1:0]      slice_cnt_q, slice_cnt_d;
  logic [AsmWidth-1:0]    asm_q, asm_d;
  logic [TDEST_WIDTH-1:0] asm_dest_q, asm_dest_d;

  logic                   tvalid_q, tvalid_d;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                   tlast_q, tlast_d;
  logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
  logic                   credit_q, credit_d;
  logic                   overflow_q, overflow_d;
  logic                   tail_err_q, tail_err_d;

  logic                   fifo_empty, fifo_full;
  logic [FLIT_WIDTH-1:0]  head_data;
  logic [TDEST_WIDTH-1:0] head_dest;
  logic                   head_tail;
  logic                   closing, out_avail, pop, push, load;
  logic [TDATA_WIDTH-1:0] beat;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FullCnt);
  assign head_data  = data_mem[rd_ptr_q];
  assign head_dest  = dest_mem[rd_ptr_q];
  assign head_tail  = tail_mem[rd_ptr_q];

  // The head flit closes the beat either as the final slice or as an early tail.
  assign closing   = (slice_cnt_q == LastSlice) | head_tail;
  // Output register can take a new beat if empty or being drained this cycle.
  assign out_avail = ~tvalid_q | axis_tready;
  assign pop       = ~fifo_empty & (~closing | out_avail);
  // A full FIFO still accepts a flit when a pop frees a slot in the same cycle.
  assign push      = send_in & (~fifo_full | pop);
  assign load      = pop & closing;

  // Beat image if the head flit closes it now: earlier slices come from the
  // assembly register, the head sits at slice_cnt, and anything above is zero.
  always_comb begin
    beat = '0;
    for (int i = 0; i < int'(SERIALIZATION_FACTOR) - 1; i++) begin
      if (SliceW'(i) < slice_cnt_q) begin
        beat[i*FLIT_WIDTH +: FLIT_WIDTH] = asm_q[i*FLIT_WIDTH +: FLIT_WIDTH];
      end else if (SliceW'(i) == slice_cnt_q) begin
        beat[i*FLIT_WIDTH +: FLIT_WIDTH] = head_data;
      end
    end
    if (slice_cnt_q == LastSlice) begin
      beat[TDATA_WIDTH-1 -: FLIT_WIDTH] = head_data;
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CntW'(push) - CntW'(pop);
    slice_cnt_d = slice_cnt_q;
    asm_d       = asm_q;
    asm_dest_d  = asm_dest_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tlast_d     = tlast_q;
    tdest_d     = tdest_q;
    credit_d    = pop;
    overflow_d  = overflow_q | (send_in & ~push);
    tail_err_d  = tail_err_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end

    if (tvalid_q && axis_tready) begin
      tvalid_d = 1'b0;
    end

    if (load) begin
      tvalid_d    = 1'b1;
      tdata_d     = beat;
      tlast_d     = head_tail;
      tdest_d     = (slice_cnt_q == '0) ? head_dest : asm_dest_q;
      slice_cnt_d = '0;
      if (head_tail && (slice_cnt_q != LastSlice)) begin
        tail_err_d = 1'b1;
      end
    end else if (pop) begin
      for (int i = 0; i < int'(SERIALIZATION_FACTOR) - 1; i++) begin
        if (slice_cnt_q == SliceW'(i)) begin
          asm_d[i*FLIT_WIDTH +: FLIT_WIDTH] = head_data;
        end
      end
      if (slice_cnt_q == '0) begin
        asm_dest_d = head_dest;
      end
      slice_cnt_d = slice_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= data_in;
      dest_mem[wr_ptr_q] <= dest_in;
      tail_mem[wr_ptr_q] <= is_tail_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      slice_cnt_q <= '0;
      asm_q       <= '0;
      asm_dest_q  <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      tdest_q     <= '0;
      credit_q    <= 1'b0;
      overflow_q  <= 1'b0;
      tail_err_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      slice_cnt_q <= slice_cnt_d;
      asm_q       <= asm_d;
      asm_dest_q  <= asm_dest_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
      tdest_q     <= tdest_d;
      credit_q    <= credit_d;
      overflow_q  <= overflow_d;
      tail_err_q  <= tail_err_d;
    end
  end

  assign credit_out   = credit_q;
  assign axis_tvalid  = tvalid_q;
  assign axis_tdata   = tdata_q;
  assign axis_tlast   = tlast_q;
  assign axis_tdest   = tdest_q;
  assign overflow_err = overflow_q;
  assign tail_err     = tail_err_q;

endmodule

// File: tb/tb_axis_flit_deserializer.sv
// Directed bench for axis_flit_deserializer with SF=4, 32-bit flits, depth 4.
module tb_axis_flit_deserializer;

  localparam int unsigned TDW   = 6;
  localparam int unsigned TDATA = 128;
  localparam int unsigned SF    = 4;
  localparam int unsigned DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [31:0]    data_in;
  logic [TDW-1:0] dest_in;
  logic           is_tail_in;
  logic           send_in;
  logic           credit_out;
  logic           axis_tvalid;
  logic           axis_tready;
  logic [127:0]   axis_tdata;
  logic           axis_tlast;
  logic [TDW-1:0] axis_tdest;
  logic           overflow_err;
  logic           tail_err;

  axis_flit_deserializer #(
    .TDEST_WIDTH         (TDW),
    .TDATA_WIDTH         (TDATA),
    .SERIALIZATION_FACTOR(SF),
    .FLIT_BUFFER_DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .dest_in     (dest_in),
    .is_tail_in  (is_tail_in),
    .send_in     (send_in),
    .credit_out  (credit_out),
    .axis_tvalid (axis_tvalid),
    .axis_tready (axis_tready),
    .axis_tdata  (axis_tdata),
    .axis_tlast  (axis_tlast),
    .axis_tdest  (axis_tdest),
    .overflow_err(overflow_err),
    .tail_err    (tail_err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Handshake monitor and credit counter.
  logic [127:0]   bq_data[$];
  logic           bq_last[$];
  logic [TDW-1:0] bq_dest[$];
  int             bq_cyc[$];
  int             cyc = 0;
  int             credit_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (credit_out) credit_cnt <= credit_cnt + 1;
    if (rst_n && axis_tvalid && axis_tready) begin
      bq_data.push_back(axis_tdata);
      bq_last.push_back(axis_tlast);
      bq_dest.push_back(axis_tdest);
      bq_cyc.push_back(cyc);
    end
  end

  logic [31:0] bpd [8];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [31:0] d, input logic [TDW-1:0] de, input logic t);
    data_in    = d;
    dest_in    = de;
    is_tail_in = t;
    send_in    = 1'b1;
    step();
    send_in    = 1'b0;
  endtask

  task automatic clear_beats();
    bq_data.delete();
    bq_last.delete();
    bq_dest.delete();
    bq_cyc.delete();
  endtask

  task automatic chk_beat(input string tag, input logic [127:0] d, input logic l,
                          input logic [TDW-1:0] de);
    chk({tag, "_present"}, 128'(bq_data.size() != 0), 128'(1));
    if (bq_data.size() != 0) begin
      chk({tag, "_data"}, bq_data.pop_front(), d);
      chk({tag, "_last"}, 128'(bq_last.pop_front()), 128'(l));
      chk({tag, "_dest"}, 128'(bq_dest.pop_front()), 128'(de));
      void'(bq_cyc.pop_front());
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_tvalid"}, 128'(axis_tvalid), 128'(0));
    chk({tag, "_tdata"}, axis_tdata, 128'(0));
    chk({tag, "_tlast"}, 128'(axis_tlast), 128'(0));
    chk({tag, "_tdest"}, 128'(axis_tdest), 128'(0));
    chk({tag, "_credit"}, 128'(credit_out), 128'(0));
    chk({tag, "_ovf"}, 128'(overflow_err), 128'(0));
    chk({tag, "_tailerr"}, 128'(tail_err), 128'(0));
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    send_in = 1'b0;
    idle(2);
    rst_n   = 1'b1;
  endtask

  // Credit-respecting sender over the bpd[] flit list.
  task automatic sender(input int cycles, input int limit, inout int avail, inout int sent,
                        inout int crd);
    for (int c = 0; c < cycles; c++) begin
      if (credit_out) begin
        avail++;
        crd++;
      end
      if (avail > 0 && sent < limit) begin
        data_in    = bpd[sent];
        dest_in    = (sent < 4) ? 6'h11 : 6'h22;
        is_tail_in = (sent == 3) || (sent == 7);
        send_in    = 1'b1;
        avail--;
        sent++;
      end else begin
        send_in = 1'b0;
      end
      step();
    end
    send_in = 1'b0;
  endtask

  function automatic logic [31:0] sval(int b, int s);
    return {8'(b), 8'(s), 16'hA5C3};
  endfunction

  initial begin
    logic [127:0] e;
    int c0, avail, sent, crd;

    rst_n       = 1'b0;
    send_in     = 1'b0;
    data_in     = '0;
    dest_in     = '0;
    is_tail_in  = 1'b0;
    axis_tready = 1'b1;
    for (int i = 0; i < 8; i++) bpd[i] = 32'hB000_0000 + 32'(i);

    // Reset values
    idle(3);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    step();

    // Single beat
    clear_beats();
    c0 = credit_cnt;
    send(32'h1111_1111, 6'h2A, 1'b0);
    send(32'h2222_2222, 6'h2A, 1'b0);
    send(32'h3333_3333, 6'h2A, 1'b0);
    send(32'h4444_4444, 6'h2A, 1'b1);
    chk("single_tvalid_early", 128'(axis_tvalid), 128'(0));
    step();
    chk("single_tvalid", 128'(axis_tvalid), 128'(1));
    chk("single_tdata", axis_tdata, 128'h44444444_33333333_22222222_11111111);
    chk("single_tdest", 128'(axis_tdest), 128'(6'h2A));
    chk("single_tlast", 128'(axis_tlast), 128'(1));
    idle(4);
    chk("single_credits", 128'(credit_cnt - c0), 128'(4));
    chk("single_tvalid_drop", 128'(axis_tvalid), 128'(0));

    // Stream: 8 back-to-back beats
    clear_beats();
    c0 = credit_cnt;
    for (int b = 0; b < 8; b++)
      for (int s = 0; s < 4; s++)
        send(sval(b, s), 6'(b + 1), (b == 7) && (s == 3));
    idle(8);
    chk("stream_beats", 128'(bq_data.size()), 128'(8));
    if (bq_cyc.size() == 8)
      for (int b = 1; b < 8; b++)
        chk($sformatf("stream_gap%0d", b), 128'(bq_cyc[b] - bq_cyc[b-1]), 128'(4));
    for (int b = 0; b < 8; b++) begin
      e = {sval(b, 3), sval(b, 2), sval(b, 1), sval(b, 0)};
      chk_beat($sformatf("stream_b%0d", b), e, b == 7, 6'(b + 1));
    end
    chk("stream_credits", 128'(credit_cnt - c0), 128'(32));
    chk("stream_ovf", 128'(overflow_err), 128'(0));
    chk("stream_tailerr", 128'(tail_err), 128'(0));

    // Backpressure: a beat is already held, then a credit-respecting sender
    clear_beats();
    axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'hC0DE_0000 + 32'(i), 6'h05, i == 3);
    idle(4);
    chk("bp_held", 128'(axis_tvalid), 128'(1));
    avail = 4;
    sent  = 0;
    crd   = 0;
    sender(20, 8, avail, sent, crd);
    chk("bp_accepted", 128'(sent), 128'(DEPTH + 3));
    chk("bp_credits", 128'(crd), 128'(3));
    chk("bp_credit_idle", 128'(credit_out), 128'(0));
    chk("bp_held_data", axis_tdata, {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000});
    axis_tready = 1'b1;
    sender(20, 8, avail, sent, crd);
    chk("bp_all_sent", 128'(sent), 128'(8));
    chk("bp_credits_back", 128'(avail), 128'(4));
    chk_beat("bp_p", {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000}, 1'b1, 6'h05);
    chk_beat("bp_a", {bpd[3], bpd[2], bpd[1], bpd[0]}, 1'b1, 6'h11);
    chk_beat("bp_b", {bpd[7], bpd[6], bpd[5], bpd[4]}, 1'b1, 6'h22);
    chk("bp_ovf", 128'(overflow_err), 128'(0));

    // Overflow: held beat, 3 slices assembled, then 5 blind sends
    clear_beats();
    c0 = credit_cnt;
    axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'hCC00_0000 + 32'(i), 6'h0C, i == 3);
    for (int i = 0; i < 3; i++) send(32'hEE00_0000 + 32'(i), (i == 0) ? 6'h0E : 6'h01, 1'b0);
    for (int i = 0; i < 4; i++) send(32'hDD00_0000 + 32'(i), (i == 1) ? 6'h0D : 6'h02, i == 0);
    chk("ovf_full_ok", 128'(overflow_err), 128'(0));
    send(32'hDD00_0004, 6'h03, 1'b0);
    chk("ovf_set", 128'(overflow_err), 128'(1));
    axis_tready = 1'b1;
    idle(8);
    send(32'hDD00_0005, 6'h04, 1'b1);
    idle(8);
    chk_beat("ovf_c", {32'hCC00_0003, 32'hCC00_0002, 32'hCC00_0001, 32'hCC00_0000}, 1'b1, 6'h0C);
    chk_beat("ovf_e", {32'hDD00_0000, 32'hEE00_0002, 32'hEE00_0001, 32'hEE00_0000}, 1'b1, 6'h0E);
    chk_beat("ovf_d", {32'hDD00_0005, 32'hDD00_0003, 32'hDD00_0002, 32'hDD00_0001}, 1'b1, 6'h0D);
    chk("ovf_no_extra", 128'(bq_data.size()), 128'(0));
    chk("ovf_credits", 128'(credit_cnt - c0), 128'(12));
    chk("ovf_sticky", 128'(overflow_err), 128'(1));
    chk("ovf_tailerr", 128'(tail_err), 128'(0));

    // Early tail on slice 1
    do_reset();
    chk("et_ovf_cleared", 128'(overflow_err), 128'(0));
    clear_beats();
    send(32'hAAAA_0000, 6'h03, 1'b0);
    send(32'hAAAA_0001, 6'h04, 1'b1);
    for (int i = 0; i < 4; i++) send(32'h7777_0000 + 32'(i), (i == 0) ? 6'h07 : 6'h08, i == 3);
    idle(6);
    chk("et_tailerr", 128'(tail_err), 128'(1));
    chk_beat("et_x", {32'h0, 32'h0, 32'hAAAA_0001, 32'hAAAA_0000}, 1'b1, 6'h03);
    chk_beat("et_y", {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000}, 1'b1, 6'h07);

    // Mid-beat reset
    do_reset();
    idle(2);
    clear_beats();
    send(32'h5A5A_0000, 6'h15, 1'b0);
    send(32'h5A5A_0001, 6'h15, 1'b0);
    rst_n = 1'b0;
    step();
    chk_outputs_zero("mid_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(32'h9999_0000 + 32'(i), 6'h19, i == 3);
    idle(6);
    chk_beat("mid_w", {32'h9999_0003, 32'h9999_0002, 32'h9999_0001, 32'h9999_0000}, 1'b1, 6'h19);
    chk("mid_no_extra", 128'(bq_data.size()), 128'(0));
    chk("mid_tailerr", 128'(tail_err), 128'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
